// File: rtl/instr_serial_tx.sv
// Instruction-word serializer: captures a WIDTH-bit word and shifts it out MSB first.
// Latency: MSB on instr_out the cycle after acceptance; tx_done one cycle after the last bit (or parity).
// Backpressure: instr_ready is high only in IDLE; instr_valid outside IDLE is ignored.
// Optional parity stage is compiled in when INSTR_TX_PARITY_EN is defined.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module instr_serial_tx #(
  parameter int WIDTH = `INST_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic [WIDTH-1:0] instr_word,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             instr_out,
  output logic             instr_out_en,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef INSTR_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
`ifdef INSTR_TX_PARITY_EN
  logic             r_par;
`endif

  assign w_accept = (r_state == IDLE) && instr_valid;
  assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // State register; reset aborts any transfer immediately.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; all outputs are pure functions of state so reset reaches them at once.
  always_comb begin
    w_next       = r_state;
    instr_ready  = 1'b0;
    instr_out    = 1'b0;
    instr_out_en = 1'b0;
    busy         = 1'b0;
    tx_done      = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        tx_done     = r_done;
        if (instr_valid) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        busy         = 1'b1;
        instr_out_en = 1'b1;
        instr_out    = r_hold[WIDTH-1];
        if (w_last) begin
`ifdef INSTR_TX_PARITY_EN
          w_next = PAR;
`else
          w_next = IDLE;
`endif
        end
      end
`ifdef INSTR_TX_PARITY_EN
      PAR: begin
        // Parity bit is on the line but deliberately not flagged as a data bit.
        busy      = 1'b1;
        instr_out = r_par;
        w_next    = IDLE;
      end
`endif
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Holding shift register, bit counter and the completion flag feeding tx_done.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_hold <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
`ifdef INSTR_TX_PARITY_EN
      r_par  <= 1'b0;
`endif
    end else begin
      // Completion is any return to IDLE from an active state.
      r_done <= (r_state != IDLE) && (w_next == IDLE);
      if (w_accept) begin
        r_hold <= instr_word;
        r_cnt  <= '0;
`ifdef INSTR_TX_PARITY_EN
        // Odd parity taken from the captured word, before shifting destroys it.
        r_par  <= ~^instr_word;
`endif
      end else if (r_state == SHIFT) begin
        r_hold <= {r_hold[WIDTH-2:0], 1'b0};
        r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

endmodule
